// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one full-adder cell stepped over WIDTH bits, LSB first.
// Operands are captured on start. A one-cycle done pulse marks the registered sum/cout.
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    bitcnt_q, bitcnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             fa_sum, fa_cout;
  logic             last_bit;
  logic [WIDTH-1:0] sum_next;

  // The single 1-bit full-adder cell, fed from the low end of the shifters.
  always_comb begin
    fa_sum  = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
    fa_cout = (a_sh_q[0] & b_sh_q[0]) | (carry_q & (a_sh_q[0] ^ b_sh_q[0]));
  end

  // New sum bit enters at the MSB so that after WIDTH steps bit 0 sits at the LSB.
  if (WIDTH == 1) begin : g_sum_w1
    assign sum_next = fa_sum;
  end else begin : g_sum_wn
    assign sum_next = {fa_sum, sum_sh_q[WIDTH-1:1]};
  end

  assign last_bit = (bitcnt_q == CW'(WIDTH - 1));

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    sum_sh_d = sum_sh_q;
    sum_d    = sum_q;
    bitcnt_d = bitcnt_q;
    carry_d  = carry_q;
    cout_d   = cout_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_sh_d   = a;
          b_sh_d   = b;
          carry_d  = cin;
          bitcnt_d = '0;
          busy_d   = 1'b1;
          state_d  = RUN;
        end
      end
      RUN: begin
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        sum_sh_d = sum_next;
        carry_d  = fa_cout;
        bitcnt_d = bitcnt_q + CW'(1);
        if (last_bit) begin
          sum_d   = sum_next;
          cout_d  = fa_cout;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      sum_sh_q <= '0;
      sum_q    <= '0;
      bitcnt_q <= '0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      sum_sh_q <= sum_sh_d;
      sum_q    <= sum_d;
      bitcnt_q <= bitcnt_d;
      carry_q  <= carry_d;
      cout_q   <= cout_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed and random checks of serial_add_ctrl at WIDTH 8, 13 and 1.
module tb_serial_add_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic        start8 = 1'b0, cin8 = 1'b0, busy8, done8, cout8;
  logic [7:0]  a8 = '0, b8 = '0, sum8;
  logic        start13 = 1'b0, cin13 = 1'b0, busy13, done13, cout13;
  logic [12:0] a13 = '0, b13 = '0, sum13;
  logic        start1 = 1'b0, cin1 = 1'b0, busy1, done1, cout1;
  logic [0:0]  a1 = '0, b1 = '0, sum1;

  int nvec = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  serial_add_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );
  serial_add_ctrl #(.WIDTH(13)) dut13 (
    .clk(clk), .rst(rst), .start(start13), .a(a13), .b(b13), .cin(cin13),
    .busy(busy13), .done(done13), .sum(sum13), .cout(cout13)
  );
  serial_add_ctrl #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] s;
    logic       co;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string nm, input longint got, input longint exp);
    nvec++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
    end
  endtask

  task automatic drive(input int w, input bit s, input longint ta, input longint tb, input bit tc);
    case (w)
      8:       begin start8  = s; a8  = ta[7:0];  b8  = tb[7:0];  cin8  = tc; end
      13:      begin start13 = s; a13 = ta[12:0]; b13 = tb[12:0]; cin13 = tc; end
      default: begin start1  = s; a1  = ta[0:0];  b1  = tb[0:0];  cin1  = tc; end
    endcase
  endtask

  function automatic bit get_done(input int w);
    case (w)
      8:       return done8;
      13:      return done13;
      default: return done1;
    endcase
  endfunction

  function automatic bit get_busy(input int w);
    case (w)
      8:       return busy8;
      13:      return busy13;
      default: return busy1;
    endcase
  endfunction

  function automatic longint get_sum(input int w);
    case (w)
      8:       return longint'(sum8);
      13:      return longint'(sum13);
      default: return longint'(sum1);
    endcase
  endfunction

  function automatic bit get_cout(input int w);
    case (w)
      8:       return cout8;
      13:      return cout13;
      default: return cout1;
    endcase
  endfunction

  // One complete operation: accept, wait (bounded) for done, check result and timing.
  task automatic run_op(input int w, input longint ta, input longint tb, input bit tc,
                        input longint exp_sum, input bit exp_cout, input bit scramble,
                        input string nm);
    int lat;
    int nb;
    bit seen;
    drive(w, 1'b1, ta, tb, tc);
    @(posedge clk); #1;
    drive(w, 1'b0, ta, tb, tc);
    lat = 0; nb = 0; seen = 1'b0;
    while (!seen && lat < 40) begin
      if (get_busy(w)) nb++;
      if (scramble) drive(w, 1'b0, longint'($urandom), longint'($urandom), 1'($urandom_range(0, 1)));
      @(posedge clk); #1;
      lat++;
      if (get_done(w)) seen = 1'b1;
    end
    check({nm, " latency"}, lat, w);
    check({nm, " busy cycles"}, nb, w);
    check({nm, " busy with done"}, longint'(get_busy(w)), 0);
    check({nm, " sum"}, get_sum(w), exp_sum);
    check({nm, " cout"}, longint'(get_cout(w)), longint'(exp_cout));
    @(posedge clk); #1;
    check({nm, " done pulse width"}, longint'(get_done(w)), 0);
  endtask

  initial begin
    int extra;
    longint ta, tb, tot;
    bit tc;

    vecs[0] = '{a: 8'h5A, b: 8'h3C, cin: 1'b0, s: 8'h96, co: 1'b0};
    vecs[1] = '{a: 8'hFF, b: 8'h01, cin: 1'b0, s: 8'h00, co: 1'b1};
    vecs[2] = '{a: 8'hFF, b: 8'h00, cin: 1'b1, s: 8'h00, co: 1'b1};
    vecs[3] = '{a: 8'h00, b: 8'h00, cin: 1'b0, s: 8'h00, co: 1'b0};
    vecs[4] = '{a: 8'h80, b: 8'h80, cin: 1'b0, s: 8'h00, co: 1'b1};
    vecs[5] = '{a: 8'h7F, b: 8'h01, cin: 1'b1, s: 8'h81, co: 1'b0};
    vecs[6] = '{a: 8'hAA, b: 8'h55, cin: 1'b0, s: 8'hFF, co: 1'b0};
    vecs[7] = '{a: 8'hFF, b: 8'hFF, cin: 1'b1, s: 8'hFF, co: 1'b1};

    // Reset state, before any clock edge.
    #3;
    check("reset busy", longint'(busy8), 0);
    check("reset done", longint'(done8), 0);
    check("reset sum", longint'(sum8), 0);
    check("reset cout", longint'(cout8), 0);
    #9 rst = 1'b0;
    @(posedge clk); #1;

    foreach (vecs[i])
      run_op(8, longint'(vecs[i].a), longint'(vecs[i].b), vecs[i].cin,
             longint'(vecs[i].s), vecs[i].co, 1'b0, $sformatf("vec%0d", i));

    // start re-asserted during RUN and in DONE is ignored.
    drive(8, 1'b1, 'h11, 'h22, 1'b0);
    @(posedge clk); #1;
    drive(8, 1'b0, 'h00, 'h00, 1'b0);
    extra = 0;
    for (int k = 1; k <= 8; k++) begin
      drive(8, (k == 3 || k == 6), 'hFF, 'hFF, 1'b1);
      if (k == 5) check("hold sum in run", longint'(sum8), longint'(vecs[7].s));
      @(posedge clk); #1;
      if (k < 8 && done8) extra++;
    end
    check("ignore start done", longint'(done8), 1);
    check("ignore start sum", longint'(sum8), 'h33);
    check("ignore start cout", longint'(cout8), 0);
    check("ignore start early done", extra, 0);
    drive(8, 1'b1, 'h40, 'h05, 1'b1);
    @(posedge clk); #1;
    check("start in done ignored busy", longint'(busy8), 0);
    check("start in done pulse", longint'(done8), 0);
    @(posedge clk); #1;
    check("start in idle accepted", longint'(busy8), 1);
    drive(8, 1'b0, 'hAA, 'hAA, 1'b0);
    repeat (8) begin @(posedge clk); #1; end
    check("reaccept done", longint'(done8), 1);
    check("reaccept sum", longint'(sum8), 'h46);
    check("reaccept cout", longint'(cout8), 0);
    @(posedge clk); #1;
    check("reaccept pulse", longint'(done8), 0);

    // Operands changing every RUN cycle must not disturb the result.
    run_op(8, 'h81, 'h7F, 1'b1, 'h01, 1'b1, 1'b1, "scramble");

    // Asynchronous reset mid-RUN.
    drive(8, 1'b1, 'h55, 'h0F, 1'b0);
    @(posedge clk); #1;
    drive(8, 1'b0, 'h55, 'h0F, 1'b0);
    repeat (4) begin @(posedge clk); #1; end
    #2 rst = 1'b1;
    #1;
    check("midrun rst busy", longint'(busy8), 0);
    check("midrun rst done", longint'(done8), 0);
    check("midrun rst sum", longint'(sum8), 0);
    check("midrun rst cout", longint'(cout8), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    extra = 0;
    repeat (12) begin @(posedge clk); #1; if (done8) extra++; end
    check("no done after rst", extra, 0);
    run_op(8, 'h10, 'h20, 1'b0, 'h30, 1'b0, 1'b0, "after rst");

    for (int i = 0; i < 1000; i++) begin
      ta = longint'($urandom_range(0, 255));
      tb = longint'($urandom_range(0, 255));
      tc = 1'($urandom_range(0, 1));
      tot = ta + tb + longint'(tc);
      run_op(8, ta, tb, tc, tot & 'hFF, tot[8], 1'b0, "rand8");
    end

    run_op(13, 'h1FFF, 'h0001, 1'b0, 'h0000, 1'b1, 1'b0, "w13 wrap");
    run_op(13, 'h1234, 'h0ABC, 1'b1, 'h1CF1, 1'b0, 1'b0, "w13 dir");
    for (int i = 0; i < 100; i++) begin
      ta = longint'($urandom_range(0, 8191));
      tb = longint'($urandom_range(0, 8191));
      tc = 1'($urandom_range(0, 1));
      tot = ta + tb + longint'(tc);
      run_op(13, ta, tb, tc, tot & 'h1FFF, tot[13], 1'b0, "rand13");
    end

    for (int i = 0; i < 8; i++) begin
      ta = longint'(i & 1);
      tb = longint'((i >> 1) & 1);
      tc = 1'((i >> 2) & 1);
      tot = ta + tb + longint'(tc);
      run_op(1, ta, tb, tc, tot & 1, tot[1], 1'b0, $sformatf("w1 case%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
